serial_add_sub_unit: RTL and testbench
======================================

// Module: serial_add_sub_unit
// PURPOSE
//  Bit-serial, mode-controlled add/subtract engine; the responder for operand transactions (a, b, m, en).
//  Computes LSB-first, one bit per clock, through a single full-adder cell; returns result, carry and overflow.
//  Sits between an operand producer (stimulus/sequencer) and a result consumer, both via valid/ready handshakes.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      operand transaction present
//  in_ready    out  1      engine can accept an operand transaction
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  in_m        in   1      mode: 0 = A+B, 1 = A-B (A + ~B + 1)
//  in_en       in   1      enable: 0 = result/carry/overflow forced to 0
//  out_valid   out  1      result transaction present
//  out_ready   in   1      consumer accepts result
//  out_result  out  WIDTH  sum/difference, modulo 2^WIDTH
//  out_carry   out  1      carry out of MSB (subtract: 1 = no borrow, A>=B unsigned)
//  out_ovf     out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; out_result=0; out_carry=0; out_ovf=0;
//   shift registers, bit counter, carry flop cleared. Reset mid-SHIFT or mid-DONE aborts; transaction is lost.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE : in_ready=1. On in_valid&&in_ready edge: load A, B regs; carry flop <= in_m; latch m, en; cnt<=0; ->SHIFT.
//   SHIFT: in_ready=0. Each edge: s = A[0] ^ (B[0]^m) ^ c; c <= maj(A[0], B[0]^m, c);
//          A,B shift right; result reg shifts right with s into MSB; cnt++.
//          On bit WIDTH-1: record carry-in to MSB for ovf; final c is carry out; ->DONE.
//   DONE : out_valid=1; out_result/out_carry/out_ovf stable (en=0 -> all 0). On out_valid&&out_ready edge ->IDLE.
//  Latency: acceptance edge E0; out_valid high from edge E(WIDTH) until the output handshake edge.
//  Throughput: one transaction per WIDTH+2 cycles minimum; in_ready never high while SHIFT or DONE.
//  in_* are sampled only on the acceptance edge; changes at any other time have no effect.
//  out_ready held low: DONE persists indefinitely; outputs hold, no new operands accepted.
//  Outputs remain at last result values after return to IDLE (out_valid=0 qualifies them).
//  Arithmetic: unsigned wrap modulo 2^WIDTH; carry/ovf as defined above; no saturation.
// STRUCTURE
//  Shared package add_sub_pkg: state enum {IDLE, SHIFT, DONE}; constants MODE_ADD=1'b0, MODE_SUB=1'b1.
//  One sub-module: full_adder (a, b, cin -> sum, cout), single instance in the serial datapath.
//  Bit counter width $clog2(WIDTH); all state in this module, no other hierarchy.
// TESTING (WIDTH=4)
//  1. Reset: rst_n=0 mid-run -> in_ready=1, out_valid=0, out_result=0, out_carry=0, out_ovf=0 immediately.
//  2. Add: a=0001 b=0101 m=0 en=1 -> after 4 cycles result=0110 carry=0 ovf=0; a=0111 b=0101 -> 1100 c=0 ovf=1.
//  3. Sub: a=0111 b=0101 m=1 en=1 -> 0010 c=1; a=0011 b=1101 m=1 -> 0110 c=0 ovf=0.
//  4. Disable: a=1001 b=0111 m=0 en=0 -> out_valid after 4 cycles, result=0000 carry=0 ovf=0.
//  5. Backpressure: out_ready=0 for 6 cycles after out_valid -> outputs stable, in_ready=0, in_valid ignored.
//  6. Back-to-back: in_valid held with new operands -> each accepted only in IDLE, results in order, none lost.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Carry out of a full-adder cell.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single full-adder cell shared by every bit position of the serial datapath.
module full_adder
  import add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/serial_add_sub_unit.sv
// Bit-serial add/subtract engine: LSB-first through one full adder, valid/ready on both sides.
module serial_add_sub_unit
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_m,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-2:0] res_r;
  logic [CW-1:0]    cnt_r;
  logic             c_r;
  logic             m_r;
  logic             en_r;

  logic             b_bit_s;
  logic             sum_s;
  logic             cout_s;
  logic [WIDTH-1:0] res_next_s;

  // Subtraction inverts B bit by bit; the +1 comes from the carry flop preset to m.
  assign b_bit_s    = b_r[0] ^ m_r;
  assign res_next_s = {sum_s, res_r};

  full_adder u_fa (
    .a    (a_r[0]),
    .b    (b_bit_s),
    .cin  (c_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Control FSM, serial datapath and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      res_r      <= {(WIDTH-1){1'b0}};
      cnt_r      <= {CW{1'b0}};
      c_r        <= 1'b0;
      m_r        <= MODE_ADD;
      en_r       <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= {WIDTH{1'b0}};
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b;
            c_r      <= in_m;
            m_r      <= in_m;
            en_r     <= in_en;
            cnt_r    <= {CW{1'b0}};
            in_ready <= 1'b0;
            state_r  <= SHIFT;
          end
        end
        SHIFT: begin
          a_r   <= {1'b0, a_r[WIDTH-1:1]};
          b_r   <= {1'b0, b_r[WIDTH-1:1]};
          res_r <= res_next_s[WIDTH-1:1];
          c_r   <= cout_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          // On the MSB, c_r is still the carry into it, so ovf is c_r ^ cout.
          if (cnt_r == LAST_BIT) begin
            out_valid  <= 1'b1;
            out_result <= en_r ? res_next_s : {WIDTH{1'b0}};
            out_carry  <= en_r & cout_s;
            out_ovf    <= en_r & (c_r ^ cout_s);
            state_r    <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Directed self-checking bench for serial_add_sub_unit at WIDTH=4.
module tb_serial_add_sub_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_m;
  logic         in_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_ovf;

  int passed = 0;
  int total  = 0;

  serial_add_sub_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_m       (in_m),
    .in_en      (in_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  // Drives one transaction from IDLE and returns latency and result; the operands are
  // scrambled right after acceptance to show they are only sampled on that edge.
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic en, output int lat, output logic [W+1:0] res);
    in_a = a; in_b = b; in_m = m; in_en = en; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_m = ~m; in_en = ~en;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {out_result, out_carry, out_ovf};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_a = 4'b0000; in_b = 4'b0000;
    in_m = 1'b0; in_en = 1'b0; out_ready = 1'b0;
    #12;
    total++;
    if ({in_ready, out_valid, out_result, out_carry, out_ovf} !== 8'b1000_0000)
      $display("FAIL reset_state: got %b expected %b",
               {in_ready, out_valid, out_result, out_carry, out_ovf}, 8'b1000_0000);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL reset_release: got %b expected %b", {in_ready, out_valid}, 2'b10);
    else passed++;
  endtask

  task automatic test_add;
    int lat;
    logic [W+1:0] res;
    do_txn(4'b0001, 4'b0101, 1'b0, 1'b1, lat, res);
    total++;
    if (lat !== 4) $display("FAIL add1_latency: got %0d expected %0d", lat, 4);
    else passed++;
    total++;
    if (res !== 6'b0110_0_0) $display("FAIL add1_result: got %b expected %b", res, 6'b0110_0_0);
    else passed++;
    total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL add1_return_idle: got %b expected %b", {in_ready, out_valid}, 2'b10);
    else passed++;
    total++;
    if (out_result !== 4'b0110)
      $display("FAIL add1_hold_after_idle: got %b expected %b", out_result, 4'b0110);
    else passed++;
    do_txn(4'b0111, 4'b0101, 1'b0, 1'b1, lat, res);
    total++;
    if (res !== 6'b1100_0_1) $display("FAIL add2_ovf: got %b expected %b", res, 6'b1100_0_1);
    else passed++;
    do_txn(4'b1111, 4'b0001, 1'b0, 1'b1, lat, res);
    total++;
    if (res !== 6'b0000_1_0) $display("FAIL add3_wrap: got %b expected %b", res, 6'b0000_1_0);
    else passed++;
  endtask

  task automatic test_sub;
    int lat;
    logic [W+1:0] res;
    do_txn(4'b0111, 4'b0101, 1'b1, 1'b1, lat, res);
    total++;
    if (res !== 6'b0010_1_0) $display("FAIL sub1_result: got %b expected %b", res, 6'b0010_1_0);
    else passed++;
    do_txn(4'b0011, 4'b1101, 1'b1, 1'b1, lat, res);
    total++;
    if (res !== 6'b0110_0_0) $display("FAIL sub2_borrow: got %b expected %b", res, 6'b0110_0_0);
    else passed++;
    do_txn(4'b0000, 4'b0000, 1'b1, 1'b1, lat, res);
    total++;
    if (res !== 6'b0000_1_0) $display("FAIL sub3_zero: got %b expected %b", res, 6'b0000_1_0);
    else passed++;
    do_txn(4'b1000, 4'b0001, 1'b1, 1'b1, lat, res);
    total++;
    if (res !== 6'b0111_1_1) $display("FAIL sub4_ovf: got %b expected %b", res, 6'b0111_1_1);
    else passed++;
  endtask

  task automatic test_disable;
    int lat;
    logic [W+1:0] res;
    do_txn(4'b1001, 4'b0111, 1'b0, 1'b0, lat, res);
    total++;
    if (lat !== 4) $display("FAIL dis_latency: got %0d expected %0d", lat, 4);
    else passed++;
    total++;
    if (res !== 6'b0000_0_0) $display("FAIL dis_result: got %b expected %b", res, 6'b0000_0_0);
    else passed++;
  endtask

  task automatic test_backpressure;
    int lat;
    logic [W+1:0] res;
    int bad_out, bad_ready;
    in_a = 4'b0101; in_b = 4'b0011; in_m = 1'b0; in_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 4'b0001; in_b = 4'b0001;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 4) $display("FAIL bp_latency: got %0d expected %0d", lat, 4);
    else passed++;
    bad_out = 0; bad_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if ({out_valid, out_result, out_carry, out_ovf} !== 7'b1_1000_0_1) bad_out++;
      if (in_ready !== 1'b0) bad_ready++;
    end
    total++;
    if (bad_out !== 0) $display("FAIL bp_hold_outputs: got %0d unstable cycles expected %0d", bad_out, 0);
    else passed++;
    total++;
    if (bad_ready !== 0) $display("FAIL bp_in_ready: got %0d cycles high expected %0d", bad_ready, 0);
    else passed++;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_ignored_input: got %b expected %b", {in_ready, out_valid}, 2'b10);
    else passed++;
    res = 6'b0;
    do_txn(4'b0100, 4'b0010, 1'b1, 1'b1, lat, res);
    total++;
    if (res !== 6'b0010_1_0) $display("FAIL bp_next_txn: got %b expected %b", res, 6'b0010_1_0);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a_v [3] = '{4'b0010, 4'b1110, 4'b0110};
    logic [W-1:0] b_v [3] = '{4'b0011, 4'b0011, 4'b0110};
    logic         m_v [3] = '{1'b0, 1'b1, 1'b0};
    logic [W+1:0] e_v [3] = '{6'b0101_0_0, 6'b1011_1_0, 6'b1100_0_1};
    int cyc;
    int ready_high;
    out_ready = 1'b1; in_en = 1'b1; in_valid = 1'b1;
    in_a = a_v[0]; in_b = b_v[0]; in_m = m_v[0];
    for (int k = 0; k < 3; k++) begin
      total++;
      if (in_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b expected %b", k, in_ready, 1'b1);
      else passed++;
      @(posedge clk); #1;
      if (k < 2) begin
        in_a = a_v[k+1]; in_b = b_v[k+1]; in_m = m_v[k+1];
      end else begin
        in_valid = 1'b0;
      end
      cyc = 0; ready_high = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
        if (in_ready !== 1'b0) ready_high++;
        @(posedge clk); #1;
        cyc++;
      end
      if (in_ready !== 1'b0) ready_high++;
      total++;
      if ({cyc, ready_high} !== {32'd4, 32'd0})
        $display("FAIL b2b_timing_%0d: got lat %0d ready_high %0d expected lat 4 ready_high 0",
                 k, cyc, ready_high);
      else passed++;
      total++;
      if ({out_result, out_carry, out_ovf} !== e_v[k])
        $display("FAIL b2b_result_%0d: got %b expected %b", k,
                 {out_result, out_carry, out_ovf}, e_v[k]);
      else passed++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int lat;
    logic [W+1:0] res;
    do_txn(4'b0001, 4'b0101, 1'b0, 1'b1, lat, res);
    in_a = 4'b0111; in_b = 4'b0101; in_m = 1'b0; in_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_result, out_carry, out_ovf} !== 8'b1000_0000)
      $display("FAIL midrun_reset: got %b expected %b",
               {in_ready, out_valid, out_result, out_carry, out_ovf}, 8'b1000_0000);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn(4'b0011, 4'b0010, 1'b0, 1'b1, lat, res);
    total++;
    if ({lat, res} !== {32'd4, 6'b0101_0_0})
      $display("FAIL midrun_recover: got lat %0d res %b expected lat 4 res %b", lat, res, 6'b0101_0_0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_disable();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
